// File: rtl/rbp_pkg.sv
// Shared command codes and FSM state encoding for the rbp link master.
package rbp_pkg;

   localparam int unsigned RBP_DATA_W = 16;
   localparam int unsigned RBP_CMD_W  = 4;

   localparam logic [RBP_CMD_W-1:0] RBP_CMD_CLR  = 4'h0;
   localparam logic [RBP_CMD_W-1:0] RBP_CMD_READ = 4'h1;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      SETUP,
      REQ_HI,
      REQ_LO,
      PUSH,
      DONE
   } rbp_state_e;

endpackage

// File: rtl/rbp_sync.sv
// Multi-flop synchronizer for the asynchronous rbp acknowledge.
module rbp_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/rbp_master.sv
// Initiator for the rbp four-phase link: clear command, N reads, stream out, timeout recovery.
// Optional RBP_MASTER_CHECKSUM_EN adds a per-session modulo-2^16 sum of streamed words.
module rbp_master
   import rbp_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned SETUP_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 4096,
   parameter int unsigned RST_CYCLES   = 8
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        start,
   input  logic [15:0] word_count,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        rbp_req,
   input  logic        rbp_ack,
   output logic        rbp_rst,
   output logic        rbp_dat,
   output logic [3:0]  rbp_cmd,
   input  logic [15:0] rbp_data
`ifdef RBP_MASTER_CHECKSUM_EN
   ,
   output logic [15:0] checksum
`endif
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + SETUP_CYCLES + 1);
   localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

   rbp_state_e        state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [RST_W-1:0]  rst_left, rst_left_n;
   logic [15:0]       wc_q, wc_n;
   logic [15:0]       count, count_n;
   logic [15:0]       data_n;
   logic [3:0]        cmd_n;
   logic              error_n;
   logic              ack_s;

   rbp_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (rbp_ack),
      .q     (ack_s)
   );

   assign rbp_dat = 1'b0;

   // State and registered outputs, all derived from the next state
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rst_left  <= '0;
         wc_q      <= '0;
         count     <= '0;
         out_data  <= '0;
         rbp_cmd   <= '0;
         error     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         rbp_req   <= 1'b0;
         rbp_rst   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         rst_left  <= rst_left_n;
         wc_q      <= wc_n;
         count     <= count_n;
         out_data  <= data_n;
         rbp_cmd   <= cmd_n;
         error     <= error_n;
         busy      <= (state_n != IDLE);
         done      <= (state_n == DONE);
         out_valid <= (state_n == PUSH);
         rbp_req   <= (state_n == REQ_HI);
         rbp_rst   <= (rst_left_n != '0);
      end
   end

   // Next-state logic; the rbp_rst pulse counter runs on in IDLE after an abort
   always_comb begin
      state_n    = state;
      cnt_n      = cnt + CNT_W'(1);
      rst_left_n = (rst_left != '0) ? rst_left - RST_W'(1) : '0;
      wc_n       = wc_q;
      count_n    = count;
      data_n     = out_data;
      cmd_n      = rbp_cmd;
      error_n    = error;

      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (start) begin
               wc_n       = word_count;
               cmd_n      = RBP_CMD_CLR;
               error_n    = 1'b0;
               count_n    = '0;
               rst_left_n = RST_W'(RST_CYCLES);
               state_n    = RST;
            end
         end
         RST: begin
            cnt_n = '0;
            if (rst_left == RST_W'(1)) state_n = SETUP;
         end
         SETUP: begin
            if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
               cnt_n   = '0;
               state_n = REQ_HI;
            end
         end
         REQ_HI: begin
            if (ack_s) begin
               if (rbp_cmd == RBP_CMD_READ) data_n = rbp_data;
               cnt_n   = '0;
               state_n = REQ_LO;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               error_n    = 1'b1;
               rst_left_n = RST_W'(RST_CYCLES);
               cnt_n      = '0;
               state_n    = IDLE;
            end
         end
         REQ_LO: begin
            if (!ack_s) begin
               cnt_n = '0;
               if (rbp_cmd == RBP_CMD_CLR) begin
                  if (wc_q == '0) begin
                     state_n = DONE;
                  end else begin
                     cmd_n   = RBP_CMD_READ;
                     state_n = SETUP;
                  end
               end else begin
                  state_n = PUSH;
               end
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               error_n    = 1'b1;
               rst_left_n = RST_W'(RST_CYCLES);
               cnt_n      = '0;
               state_n    = IDLE;
            end
         end
         PUSH: begin
            // Consumer backpressure is unbounded, so no timeout here
            cnt_n = '0;
            if (out_ready) begin
               count_n = count + 16'd1;
               state_n = (count_n == wc_q) ? DONE : SETUP;
            end
         end
         DONE: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

`ifdef RBP_MASTER_CHECKSUM_EN
   // Running sum of accepted stream words, held after completion
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                     checksum <= '0;
      else if (state == IDLE && start)    checksum <= '0;
      else if (state == PUSH && out_ready) checksum <= checksum + out_data;
   end
`endif

endmodule

// File: doc/rbp_master.md
Name: rbp_master

Overview:
- Initiator side of the rbp four-phase request/acknowledge link; the capture block is the responder.
- On `start`, issues one clear-address command (cmd 0), then `word_count` read commands (cmd 1).
- Each returned 16-bit sample is forwarded on a valid/ready stream to the consumer (UART dump or display path).
- Supervises the link: per-transaction ack timeout, recovery pulse on `rbp_rst`.

Parameters:
- SYNC_STAGES, 2: flops in the `rbp_ack` synchronizer (minimum 2).
- SETUP_CYCLES, 2: cycles `rbp_cmd` is held stable before `rbp_req` rises (minimum 1).
- TIMEOUT, 4096: cycles to wait for each `rbp_ack` edge before aborting.
- RST_CYCLES, 8: width of the `rbp_rst` recovery pulse, in cycles.

Ports:
- sys_clk  in  1  single clock, all logic on posedge.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- word_count  in  16  number of reads; latched on start; 0 means clear only.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse at normal completion.
- error  out  1  sticky timeout flag; cleared by the next accepted start.
- out_data  out  16  captured sample.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- rbp_req  out  1  request.
- rbp_ack  in  1  acknowledge, asynchronous.
- rbp_rst  out  1  link reset to responder.
- rbp_dat  out  1  reserved, driven 0.
- rbp_cmd  out  4  command code.
- rbp_data  in  16  responder data; stable while `rbp_ack` is high.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- `ack_s` is `rbp_ack` after SYNC_STAGES flops; all handshake decisions use `ack_s` only.
- States:
  - IDLE: on `start`, latch `word_count`, set `cmd`=0, clear `error` and the internal counters, go to RST.
  - RST: `rbp_rst`=1 for RST_CYCLES, then go to SETUP. Every session begins with a link reset so a stale responder ack is cleared.
  - SETUP: `rbp_cmd` driven and stable, `rbp_req`=0, held for SETUP_CYCLES, then go to REQ_HI.
  - REQ_HI: `rbp_req`=1; wait for `ack_s`=1.
    - On cmd 1, capture `rbp_data` into the out register in the same cycle `ack_s` is seen high.
    - Then go to REQ_LO.
  - REQ_LO: `rbp_req`=0; wait for `ack_s`=0.
    - cmd 0: if `word_count`==0 go to DONE, else set `cmd`=1 and go to SETUP.
    - cmd 1: go to PUSH.
  - PUSH: `out_valid`=1 holding the captured word.
    - On `out_ready`: `out_valid`=0 and issued count increments.
    - If count == `word_count`, go to DONE; else go to SETUP.
    - Backpressure is unbounded and is not subject to timeout.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `busy` = (state != IDLE).
- Timeout:
  - A counter clears on entry to REQ_HI and on entry to REQ_LO.
  - If it reaches TIMEOUT-1 while still waiting, set `error`=1, drop `rbp_req`, pulse `rbp_rst` for RST_CYCLES, go to IDLE.
  - No `done` pulse on abort; any partially captured word is discarded.
- `start` while `busy` is ignored. `start` and a timeout abort in the same cycle: the abort wins.
- Word counter is 16 bits; `word_count`=16'hFFFF is legal and runs to completion with no wrap.
- Latency per word with no backpressure: SETUP_CYCLES + 2×(responder latency + SYNC_STAGES) + 2 cycles.
- Reset asserted mid-transaction: all outputs clear immediately, including `rbp_req` and `rbp_rst`. The responder is resynchronised by the RST phase of the next session.

Optional Feature:
- Macro: RBP_MASTER_CHECKSUM_EN.
- When defined:
  - Adds output `checksum` [15:0].
  - Modulo-2^16 sum of every word accepted on the stream in the session.
  - Cleared on accepted start; valid when `done` pulses; held until the next start.
- When undefined:
  - No port and no adder.
  - All other behaviour identical.

Decomposition:
- Package `rbp_pkg`:
  - RBP_CMD_CLR=4'h0, RBP_CMD_READ=4'h1.
  - State enum: IDLE, RST, SETUP, REQ_HI, REQ_LO, PUSH, DONE.
- Sub-module `rbp_sync`: parameterised multi-flop synchronizer for `rbp_ack`, async active-low reset to 0.

Test Plan:
- Responder model acks 5 cycles after req with data 16'h1234, 16'h1235, 16'h1236; start with `word_count`=3 and `out_ready`=1.
  - Required: one cmd 0 transaction then three cmd 1 transactions.
  - Stream carries 1234, 1235, 1236; one `done` pulse; `error`=0.
- `word_count`=0 -> exactly one cmd 0 handshake, `done`, and no `out_valid`.
- Hold `out_ready`=0 for 10000 cycles with `word_count`=2.
  - Required: `out_valid` stays high with the first word and no timeout.
  - After ready is released, the second word follows.
- Responder never acks -> after TIMEOUT cycles:
  - `error`=1, `rbp_req`=0, `rbp_rst` high for 8 cycles, `busy`=0, no `done`.
  - The next start clears `error`.
- Assert sys_rst_n low while in REQ_HI -> `rbp_req`, `busy`, `out_valid` are 0 immediately; a restart then completes normally.
- With RBP_MASTER_CHECKSUM_EN: words FFFF, 0002 -> `checksum`=16'h0001 at `done`.
